// File: rtl/delay_timer_bank.sv
// delay_timer_bank: bank of independent countdown timers sharing one prescaler
// and a global pause. Each channel loads a length, counts prescaled ticks and
// pulses dn for one cycle on expiry, either one-shot or auto-reloading.
//
// Optional build macro: DELAY_TIMER_STICKY_EN adds per-channel sticky expiry
// flags (dn_sticky, cleared by clr_sticky). Without it dn_sticky reads 0 and
// clr_sticky is ignored; the port list is the same in both builds.
//
// Per-channel state table:
//   state   | meaning
//   IDLE    | channel stopped, busy=0, waiting for start
//   RUN     | channel counting prescaled ticks, busy=1
module delay_timer_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*WIDTH-1:0] len,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic                      pause,
  input  logic [SELW-1:0]           rd_sel,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       dn,
  output logic                      any_dn,
  output logic [WIDTH-1:0]          rd_count,
  input  logic [CHANNELS-1:0]       clr_sticky,
  output logic [CHANNELS-1:0]       dn_sticky
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic [CHANNELS-1:0][WIDTH-1:0] count_all;
  logic [WIDTH-1:0]               rd_count_q, rd_count_d;

  // With PRESCALE=1 the prescaler sits at 0 and tick is asserted every cycle.
  assign tick = (pre_q == PRE_LAST);

  // Prescaler next value: wraps at PRESCALE-1, holds while paused.
  always_comb begin
    pre_d = pre_q;
    if (!pause) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             dn_q, dn_d;

    // Channel next-state: cancel beats start, start beats expiry.
    always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      dn_d     = 1'b0;
      if (cancel[i]) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else if (start[i]) begin
        state_d  = ST_RUN;
        count_d  = len[i*WIDTH +: WIDTH];
        reload_d = len[i*WIDTH +: WIDTH];
        mode_d   = periodic[i];
      end else if (state_q == ST_RUN && tick && !pause) begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          dn_d = 1'b1;
          if (mode_q) begin
            count_d = reload_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        count_q  <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        dn_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        dn_q     <= dn_d;
      end
    end

    assign busy[i]      = (state_q == ST_RUN);
    assign dn[i]        = dn_q;
    assign count_all[i] = count_q;

`ifdef DELAY_TIMER_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky flag follows the visible dn pulse; a set wins over a clear.
    always_comb begin
      sticky_d = dn_q | (sticky_q & ~clr_sticky[i]);
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
      if (reset) begin
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_d;
      end
    end

    assign dn_sticky[i] = sticky_q;
`endif
  end

`ifndef DELAY_TIMER_STICKY_EN
  logic unused_clr_sticky;
  assign unused_clr_sticky = ^clr_sticky;
  assign dn_sticky = '0;
`endif

  assign any_dn = |dn;

  // Readback mux; an out-of-range select reads as zero.
  always_comb begin
    rd_count_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SELW'(i)) begin
        rd_count_d = count_all[i];
      end
    end
  end

  // Registered readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_delay_timer_bank.sv
// Bench for delay_timer_bank: two instances (A: 3 channels, PRESCALE=1;
// B: 2 channels, PRESCALE=4) checked every cycle against a timer-bank model,
// plus directed latency/period measurements and random traffic.
module tb_delay_timer_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  a_start, a_per, a_cancel, a_clr, a_busy, a_dn, a_stk;
  logic [23:0] a_len;
  logic        a_pause, a_any;
  logic [1:0]  a_rd;
  logic [7:0]  a_rdc;

  logic [1:0]  b_start, b_per, b_cancel, b_clr, b_busy, b_dn, b_stk;
  logic [15:0] b_len;
  logic        b_pause, b_any;
  logic [0:0]  b_rd;
  logic [7:0]  b_rdc;

  delay_timer_bank #(.WIDTH(8), .CHANNELS(3), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .len(a_len), .periodic(a_per),
    .cancel(a_cancel), .pause(a_pause), .rd_sel(a_rd), .busy(a_busy), .dn(a_dn),
    .any_dn(a_any), .rd_count(a_rdc), .clr_sticky(a_clr), .dn_sticky(a_stk));

  delay_timer_bank #(.WIDTH(8), .CHANNELS(2), .PRESCALE(4)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .len(b_len), .periodic(b_per),
    .cancel(b_cancel), .pause(b_pause), .rd_sel(b_rd), .busy(b_busy), .dn(b_dn),
    .any_dn(b_any), .rd_count(b_rdc), .clr_sticky(b_clr), .dn_sticky(b_stk));

  int checks = 0;
  int errors = 0;

  // Model state, indexed [instance][channel].
  int m_pre [2];
  bit m_run [2][4];
  bit m_per [2][4];
  int m_cnt [2][4];
  int m_rel [2][4];
  bit m_dn  [2][4];
  bit m_stk [2][4];
  int m_rd  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the timer bank, described by its behaviour per channel.
  task automatic model_step(input int u, input int nch, input int presc,
                            input logic [3:0] st, input logic [3:0] pe,
                            input logic [3:0] ca, input logic [3:0] cl,
                            input logic [31:0] ln, input logic pz, input int rs);
    bit tick;
    if (reset) begin
      m_pre[u] = 0;
      m_rd[u]  = 0;
      for (int c = 0; c < 4; c++) begin
        m_run[u][c] = 0; m_per[u][c] = 0; m_cnt[u][c] = 0;
        m_rel[u][c] = 0; m_dn[u][c] = 0;  m_stk[u][c] = 0;
      end
      return;
    end
    m_rd[u] = (rs < nch) ? m_cnt[u][rs] : 0;
    tick = (m_pre[u] % presc) == presc - 1;
    for (int c = 0; c < nch; c++) begin
`ifdef DELAY_TIMER_STICKY_EN
      m_stk[u][c] = m_dn[u][c] || (m_stk[u][c] && !cl[c]);
`else
      m_stk[u][c] = 0;
`endif
      m_dn[u][c] = 0;
      if (ca[c]) begin
        m_run[u][c] = 0;
        m_cnt[u][c] = 0;
      end else if (st[c]) begin
        m_run[u][c] = 1;
        m_cnt[u][c] = int'(ln[c*8 +: 8]);
        m_rel[u][c] = m_cnt[u][c];
        m_per[u][c] = pe[c];
      end else if (m_run[u][c] && tick && !pz) begin
        if (m_cnt[u][c] > 0) m_cnt[u][c] = m_cnt[u][c] - 1;
        else begin
          m_dn[u][c] = 1;
          if (m_per[u][c]) m_cnt[u][c] = m_rel[u][c];
          else m_run[u][c] = 0;
        end
      end
    end
    if (!pz) m_pre[u] = (m_pre[u] + 1) % presc;
  endtask

  function automatic logic [3:0] mv(input int u, input int which);
    logic [3:0] v = '0;
    for (int c = 0; c < 4; c++) begin
      case (which)
        0: v[c] = m_run[u][c];
        1: v[c] = m_dn[u][c];
        default: v[c] = m_stk[u][c];
      endcase
    end
    return v;
  endfunction

  // Advance one clock on both instances and compare every output with the model.
  task automatic cyc();
    logic [3:0] eb, ed, es;
    model_step(0, 3, 1, {1'b0, a_start}, {1'b0, a_per}, {1'b0, a_cancel},
               {1'b0, a_clr}, {8'h0, a_len}, a_pause, int'(a_rd));
    model_step(1, 2, 4, {2'b0, b_start}, {2'b0, b_per}, {2'b0, b_cancel},
               {2'b0, b_clr}, {16'h0, b_len}, b_pause, int'(b_rd));
    @(posedge clk);
    #1;
    eb = mv(0, 0); ed = mv(0, 1); es = mv(0, 2);
    chk("a_busy", 32'(a_busy), 32'(eb[2:0]));
    chk("a_dn", 32'(a_dn), 32'(ed[2:0]));
    chk("a_any_dn", 32'(a_any), 32'(|ed));
    chk("a_rd_count", 32'(a_rdc), 32'(m_rd[0]));
    chk("a_sticky", 32'(a_stk), 32'(es[2:0]));
    eb = mv(1, 0); ed = mv(1, 1); es = mv(1, 2);
    chk("b_busy", 32'(b_busy), 32'(eb[1:0]));
    chk("b_dn", 32'(b_dn), 32'(ed[1:0]));
    chk("b_any_dn", 32'(b_any), 32'(|ed));
    chk("b_rd_count", 32'(b_rdc), 32'(m_rd[1]));
    chk("b_sticky", 32'(b_stk), 32'(es[1:0]));
    a_start = '0; a_cancel = '0; a_clr = '0;
    b_start = '0; b_cancel = '0; b_clr = '0;
  endtask

  initial begin
    int k;
    bit seen, seen1;
    int q[$];

    reset = 1'b1;
    a_start = '0; a_per = '0; a_cancel = '0; a_clr = '0; a_len = '0; a_pause = 0; a_rd = '0;
    b_start = '0; b_per = '0; b_cancel = '0; b_clr = '0; b_len = '0; b_pause = 0; b_rd = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_rd", 32'(a_rdc), 0);
    chk("rst_sticky", 32'(a_stk), 0);
    reset = 1'b0;
    cyc();

    // One-shot len=5: dn exactly 6 cycles after the start edge, single cycle.
    a_len[7:0] = 8'd5; a_start = 3'b001; a_rd = 2'd0;
    cyc();
    k = 0; seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cyc(); k++;
      if (a_dn[0]) seen = 1;
    end
    chk("a_oneshot_latency", 32'(k), 6);
    chk("a_oneshot_busy_fall", 32'(a_busy[0]), 0);
    cyc();
    chk("a_oneshot_single", 32'(a_dn[0]), 0);
`ifdef DELAY_TIMER_STICKY_EN
    chk("sticky_set", 32'(a_stk[0]), 1);
    a_clr = 3'b001;
    cyc();
    chk("sticky_clr", 32'(a_stk[0]), 0);
`else
    chk("sticky_off", 32'(a_stk), 0);
`endif

    // Periodic len=2 at PRESCALE=4: one dn every 12 cycles.
    b_len[7:0] = 8'd2; b_per = 2'b01; b_start = 2'b01;
    cyc();
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (b_dn[0]) q.push_back(n);
    end
    chk("b_period_count", 32'(q.size() >= 4), 1);
    if (q.size() >= 4)
      for (int j = 1; j < 4; j++) chk("b_period", 32'(q[j] - q[j-1]), 12);
    chk("b_periodic_busy", 32'(b_busy[0]), 1);
    b_cancel = 2'b01;
    cyc();

    // Two channels started together expire together.
    a_len = {8'd0, 8'd3, 8'd3}; a_start = 3'b011; a_per = '0;
    cyc();
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cyc();
      if (a_dn != 0) seen = 1;
    end
    chk("a_simul_dn", 32'(a_dn), 3);
    chk("a_simul_any", 32'(a_any), 1);

    // Cancel ch1 when its count reaches 1; ch0 still expires.
    a_start = 3'b011;
    cyc(); cyc(); cyc();
    a_cancel = 3'b010;
    seen = 0; seen1 = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cyc();
      if (a_dn[0]) seen = 1;
      if (a_dn[1]) seen1 = 1;
    end
    chk("a_cancel_ch0_dn", 32'(seen), 1);
    chk("a_cancel_ch1_nodn", 32'(seen1), 0);

    // Pause for 7 cycles mid-count; a start during the pause only loads.
    a_len[7:0] = 8'd10; a_start = 3'b001;
    cyc();
    k = 0;
    repeat (3) begin cyc(); k++; end
    a_pause = 1; a_len[15:8] = 8'd4; a_start = 3'b010; a_rd = 2'd1;
    repeat (7) begin cyc(); k++; end
    chk("a_pause_loaded", 32'(a_rdc), 4);
    a_pause = 0;
    seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      cyc(); k++;
      if (a_dn[0]) seen = 1;
    end
    chk("a_pause_latency", 32'(k), 18);
    repeat (8) cyc();

    // Restart on the expiry cycle suppresses dn; next expiry 3 ticks later.
    a_len[23:16] = 8'd2; a_start = 3'b100;
    cyc(); cyc(); cyc();
    a_start = 3'b100;
    cyc();
    chk("a_restart_nodn", 32'(a_dn[2]), 0);
    k = 0; seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      cyc(); k++;
      if (a_dn[2]) seen = 1;
    end
    chk("a_restart_latency", 32'(k), 3);

    // Cancel and start together leave the channel idle.
    a_len[15:8] = 8'd5; a_start = 3'b010; a_cancel = 3'b010;
    cyc();
    chk("a_cancel_start_idle", 32'(a_busy[1]), 0);
    repeat (8) cyc();

    // Reset at count=4 clears all outputs at the next edge.
    a_len[7:0] = 8'd8; a_start = 3'b001; a_rd = 2'd0;
    cyc();
    repeat (4) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_mid_busy", 32'(a_busy), 0);
    chk("rst_mid_dn", 32'(a_dn), 0);
    chk("rst_mid_any", 32'(a_any), 0);
    chk("rst_mid_rd", 32'(a_rdc), 0);
    reset = 1'b0;
    cyc();

    // Random traffic on both instances.
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 3; c++) begin
        a_start[c]  = ($urandom_range(0, 7) == 0);
        a_cancel[c] = ($urandom_range(0, 31) == 0);
        a_per[c]    = $urandom_range(0, 1);
        a_len[c*8 +: 8] = 8'($urandom_range(0, 6));
      end
      for (int c = 0; c < 2; c++) begin
        b_start[c]  = ($urandom_range(0, 7) == 0);
        b_cancel[c] = ($urandom_range(0, 31) == 0);
        b_per[c]    = $urandom_range(0, 1);
        b_len[c*8 +: 8] = 8'($urandom_range(0, 4));
      end
      a_clr   = 3'($urandom_range(0, 7));
      b_clr   = 2'($urandom_range(0, 3));
      a_pause = ($urandom_range(0, 9) == 0);
      b_pause = ($urandom_range(0, 9) == 0);
      a_rd    = 2'($urandom_range(0, 3));
      b_rd    = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_timer_bank.md
# delay_timer_bank

Parametrised multi-channel countdown timer bank for sequencing phase lengths in the traffic-light controller. Each channel is loaded with a length, counts prescaled ticks, and emits a one-cycle done pulse on expiry, in either one-shot or periodic (auto-reload) mode. Channels share a prescaler and a global pause. The state FSM and pedestrian logic start and cancel channels independently, and can read back any channel's remaining count.

## Interface
Parameters:
- WIDTH, 32, count/length width in bits
- CHANNELS, 4, number of independent timer channels (≥1)
- PRESCALE, 1, clk cycles per tick (≥1); 1 = tick every cycle
- SELW, max(1, clog2(CHANNELS)), width of rd_sel

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  CHANNELS  per-channel start/restart request, sampled on clk rising edge
- len  in  CHANNELS*WIDTH  per-channel length; channel i occupies bits [i*WIDTH +: WIDTH]
- periodic  in  CHANNELS  mode, sampled with start: 1 = auto-reload, 0 = one-shot
- cancel  in  CHANNELS  per-channel abort
- pause  in  1  global freeze of prescaler and all countdowns
- rd_sel  in  SELW  channel index for readback
- busy  out  CHANNELS  channel is running
- dn  out  CHANNELS  one-cycle expiry pulse, registered
- any_dn  out  1  OR of dn
- rd_count  out  WIDTH  registered remaining count of channel rd_sel
- clr_sticky  in  CHANNELS  sticky-flag clear (see Configuration)
- dn_sticky  out  CHANNELS  sticky expiry flags (see Configuration)

## Operation
- Per-channel states: IDLE, RUN. The dn pulse is an output event, not a state.
- Reset: all channels IDLE; count, reload and mode registers 0; prescaler 0. busy, dn, any_dn, rd_count and dn_sticky are all 0.
- Prescaler: free-running 0..PRESCALE-1. tick = 1 in the cycle the prescaler equals PRESCALE-1; with PRESCALE=1, tick = 1 in every cycle. Holds its value while pause=1.
- IDLE --start--> RUN: count ← len[i], reload ← len[i], mode ← periodic[i], busy ← 1.
- RUN, tick, pause=0, count≠0: count ← count-1.
- RUN, tick, pause=0, count=0: dn[i] ← 1 for one cycle.
  - Periodic mode: count ← reload and the channel stays in RUN.
  - One-shot mode: the channel goes to IDLE and busy ← 0.
- Expiry therefore occurs len+1 ticks after start. len=0 gives expiry on the first tick; in periodic mode with PRESCALE=1 this means dn is continuously pulsing.
- start in RUN restarts the channel: count, reload and mode are reloaded. The pending expiry in that cycle is suppressed, so no dn.
- cancel: the channel goes to IDLE, busy ← 0, count ← 0, and no dn is asserted. cancel wins over a simultaneous start and over a simultaneous expiry.
- pause=1: count and prescaler frozen. start and cancel still take effect. A started channel waits for the next unpaused tick.
- Channels are fully independent. Simultaneous expiries assert multiple dn bits in the same cycle.
- count arithmetic is unsigned, WIDTH bits, and never wraps below 0.
- rd_count ← count[rd_sel] each cycle; it is 0 if rd_sel ≥ CHANNELS.

## Timing
- start sampled at edge E0 → busy=1 and count=len after E0.
- With PRESCALE=1 and no pause, dn=1 in the cycle after edge E(len+1), then dn=0. In one-shot mode busy falls together with the dn rise.
- Periodic mode: dn period = (len+1)·PRESCALE cycles.
- any_dn is combinational from the dn register, so it is coincident with dn.
- rd_count latency: 1 cycle after rd_sel or count changes.
- Reset asserted mid-count: the next edge forces the reset values above; no dn is emitted.

## Configuration
- Macro: DELAY_TIMER_STICKY_EN.
- Defined: dn_sticky[i] is set on every dn[i] and cleared by clr_sticky[i]. Set wins over a simultaneous clear. dn_sticky resets to 0.
- Undefined: dn_sticky is tied to 0, clr_sticky is ignored, and no sticky registers are synthesised. The port list is identical in both builds.

## Test plan
- CHANNELS=1, PRESCALE=1, len=5, one-shot start → dn high exactly 6 cycles after start edge, single cycle; busy 1→0 with dn; count reads 5,4,…,0.
- PRESCALE=4, len=2, periodic → dn every 12 cycles for ≥3 periods; busy stays 1.
- Channel 0 len=3 plus channel 1 len=3, started same cycle → both dn bits and any_dn in the same cycle; cancel ch1 at count=1 → no ch1 dn, ch0 unaffected.
- pause=1 for 7 cycles mid-count (len=10) → expiry delayed by exactly 7 cycles; a start issued during the pause loads count but does not decrement it.
- start on the expiry cycle with len=2 → no dn that cycle, next dn 3 ticks later; cancel+start same cycle → IDLE, no dn; reset at count=4 → all outputs 0 next cycle.
- DELAY_TIMER_STICKY_EN defined: dn sets dn_sticky; clr_sticky clears it; clr_sticky coinciding with dn leaves it 1. Undefined: dn_sticky is always 0.
